// File: rtl/traffic_ctrl_n.sv
// traffic_ctrl_n: round-robin multi-approach traffic light controller.
// A single phase timer advances on TICK. Pending requests are latched per channel,
// and the next green goes to the first pending channel after PHASE.
// Optional flash mode is compiled in with `define TRAFFIC_CTRL_FLASH_EN.
module traffic_ctrl_n #(
    parameter int unsigned NCH       = 4,
    parameter int unsigned TW        = 8,
    parameter int unsigned GREEN_MIN = 3,
    parameter int unsigned GREEN_MAX = 6,
    parameter int unsigned YELLOW_T  = 2,
    parameter int unsigned ALLRED_T  = 1
) (
    input  logic           CK,
    input  logic           RN,
    input  logic           TICK,
    input  logic [NCH-1:0] REQ,
`ifdef TRAFFIC_CTRL_FLASH_EN
    input  logic           FLASH,
`endif
    output logic [NCH-1:0] GREEN,
    output logic [NCH-1:0] YELLOW,
    output logic [NCH-1:0] RED,
    output logic [NCH-1:0] ACK,
    output logic [2:0]     PHASE,
    output logic [NCH-1:0] PEND
);

    localparam int unsigned PW = 3;

    // Terminal timer values: a state of length T exits when the timer reaches T-1 on a tick.
    localparam logic [TW-1:0] GMIN_LAST = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] GMAX_LAST = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] YEL_LAST  = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] AR_LAST   = TW'(ALLRED_T - 1);

    typedef enum logic [2:0] {
        S_ALLRED = 3'd0,
        S_GREEN  = 3'd1,
        S_YELLOW = 3'd2,
        S_REST   = 3'd3
`ifdef TRAFFIC_CTRL_FLASH_EN
        ,
        S_FLASH  = 3'd4
`endif
    } state_t;

    state_t          state, state_n;
    logic [TW-1:0]   timer, timer_n;
    logic [PW-1:0]   phase_n;
    logic [NCH-1:0]  pend_n;
    logic [NCH-1:0]  green_n, yellow_n, red_n, ack_n;
    logic [NCH-1:0]  oh_phase, oh_next;
    logic            oth_pend;
    logic            found;
    logic [PW-1:0]   win;

    // Round-robin search over latched requests, starting just after PHASE.
    always_comb begin
        found = 1'b0;
        win   = PHASE;
        for (int unsigned k = 1; k <= NCH; k++) begin
            int unsigned idx;
            idx = (32'(PHASE) + k) % NCH;
            if (!found && ((PEND & (NCH'(1) << idx)) != '0)) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    // Some channel other than the one being served is waiting.
    always_comb begin
        oh_phase = NCH'(1) << PHASE;
        oth_pend = |(PEND & ~oh_phase);
    end

    // Next-state, timer, request latch and lamp decode.
    always_comb begin
        state_n  = state;
        timer_n  = TICK ? timer + TW'(1) : timer;
        phase_n  = PHASE;
        pend_n   = PEND | REQ;
        ack_n    = '0;
        green_n  = '0;
        yellow_n = '0;
        red_n    = '1;
        oh_next  = '0;

        case (state)
            S_ALLRED: begin
                if (TICK && (timer == AR_LAST)) begin
                    if (found) begin
                        state_n = S_GREEN;
                        phase_n = win;
                    end else begin
                        state_n = S_REST;
                    end
                end
            end
            S_REST: begin
                if (found) begin
                    state_n = S_GREEN;
                    phase_n = win;
                end
            end
            S_GREEN: begin
                if (TICK && ((timer == GMAX_LAST) || ((timer >= GMIN_LAST) && oth_pend))) begin
                    state_n = S_YELLOW;
                end
            end
            S_YELLOW: begin
                if (TICK && (timer == YEL_LAST)) begin
                    state_n = S_ALLRED;
                end
            end
`ifdef TRAFFIC_CTRL_FLASH_EN
            S_FLASH: begin
                if (!FLASH) begin
                    state_n = S_ALLRED;
                end
            end
`endif
            default: state_n = S_ALLRED;
        endcase

`ifdef TRAFFIC_CTRL_FLASH_EN
        // Flash overrides everything, including a green grant in the same cycle.
        if (FLASH) begin
            state_n = S_FLASH;
            phase_n = PHASE;
        end
`endif

        if (state_n != state) begin
            timer_n = '0;
        end

        // Green entry grants the channel and drops its latch, even if REQ is high now.
        if ((state_n == S_GREEN) && (state != S_GREEN)) begin
            ack_n  = NCH'(1) << phase_n;
            pend_n = pend_n & ~ack_n;
        end

        oh_next = NCH'(1) << phase_n;
        case (state_n)
            S_GREEN: begin
                green_n = oh_next;
                red_n   = ~oh_next;
            end
            S_YELLOW: begin
                yellow_n = oh_next;
                red_n    = ~oh_next;
            end
`ifdef TRAFFIC_CTRL_FLASH_EN
            S_FLASH: begin
                if (state != S_FLASH) begin
                    red_n = '1;
                end else begin
                    red_n = TICK ? ~RED : RED;
                end
            end
`endif
            default: red_n = '1;
        endcase
    end

    // State, timer and registered outputs.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state  <= S_ALLRED;
            timer  <= '0;
            PEND   <= '0;
            PHASE  <= PW'(NCH - 1);
            GREEN  <= '0;
            YELLOW <= '0;
            RED    <= '1;
            ACK    <= '0;
        end else begin
            state  <= state_n;
            timer  <= timer_n;
            PEND   <= pend_n;
            PHASE  <= phase_n;
            GREEN  <= green_n;
            YELLOW <= yellow_n;
            RED    <= red_n;
            ACK    <= ack_n;
        end
    end

endmodule

// File: doc/traffic_ctrl_n.md
TRAFFIC_CTRL_N -- requirements
Module: traffic_ctrl_n

Interface
REQ-001 Parameter NCH, default 4: number of approach channels, legal range 2..8.
REQ-002 Parameter TW, default 8: width of the phase timer in bits.
REQ-003 Parameters GREEN_MIN 3, GREEN_MAX 6, YELLOW_T 2, ALLRED_T 1: phase lengths in ticks; each is 1..2^TW-1, and GREEN_MIN <= GREEN_MAX.
REQ-004 CK  input  1  rising-edge clock; the block has this one clock and no other.
REQ-005 RN  input  1  reset, asynchronous and active-low.
REQ-006 TICK  input  1  timer advance strobe; timers count only in cycles where TICK=1.
REQ-007 REQ  input  NCH  per-channel service request (vehicle sensor), level or pulse.
REQ-008 GREEN, YELLOW, RED  output  NCH each  registered lamp drives, one bit per channel.
REQ-009 ACK  output  NCH  one-cycle pulse when the channel's pending request is granted.
REQ-010 PHASE  output  3  index of the current or last served channel.
REQ-011 PEND  output  NCH  current pending-request latches.

Function
REQ-012 States are ALLRED, GREEN, YELLOW, REST, plus FLASH when the REQ-027 feature is compiled in.
REQ-013 The phase timer clears to 0 on every state entry, and increments in each cycle where TICK=1.
REQ-014 A state with length T exits on the edge where timer==T-1 and TICK=1; with TICK held at 1, the state therefore lasts exactly T cycles.
REQ-015 PEND[i] sets on the edge after REQ[i]=1.
REQ-016 PEND[i] clears on the edge where channel i enters GREEN; in that same cycle ACK[i] pulses.
REQ-017 If REQ[i]=1 in the cycle channel i enters GREEN, the clear wins and the request is dropped.
REQ-018 On ALLRED exit, the next channel is the first pending channel searched round-robin from PHASE+1 (mod NCH); if no channel is pending, go to REST.
REQ-019 REST holds all RED and leaves no sooner than the edge after any PEND bit becomes 1, then enters GREEN for the round-robin winner with no further ALLRED.
REQ-020 GREEN goes to YELLOW once timer>=GREEN_MIN-1 with TICK=1 and some other channel is pending.
REQ-021 GREEN goes to YELLOW unconditionally at timer==GREEN_MAX-1 with TICK=1.
REQ-022 YELLOW lasts YELLOW_T ticks, then enters ALLRED.
REQ-023 Lamps:
- GREEN[PHASE]=1 only in GREEN, and YELLOW[PHASE]=1 only in YELLOW.
- RED[i]=1 for every other channel and state.
- Exactly one lamp per channel is lit at all times (FLASH excepted).
REQ-024 A request arriving for the channel currently in GREEN or YELLOW latches normally and is served in a later round.

Reset
REQ-025 While RN=0, all state is held at reset values:
- state ALLRED, timer 0, PEND 0, PHASE NCH-1 (so channel 0 is searched first);
- RED all 1, GREEN 0, YELLOW 0, ACK 0.
REQ-026 Reset asserted mid-phase takes effect immediately, without waiting for CK; after release, operation restarts with a full ALLRED_T.

Configuration
REQ-027 Macro TRAFFIC_CTRL_FLASH_EN controls the flash feature.
- Defined: input port FLASH (1 bit) exists.
- FLASH=1 forces state FLASH from any state at the next edge.
- In FLASH: GREEN=0, YELLOW=0, and RED all toggle on each TICK (first value 1). No ACK is issued, but PEND keeps latching.
- FLASH=0 returns to ALLRED with timer 0 and all RED=1.
- Not defined: no FLASH port, no FLASH state, and behaviour is exactly REQ-012..REQ-026.

Verification (NCH=4, defaults, TICK=1 unless stated)
REQ-028 Reset:
- Release RN with no REQ -> after ALLRED, PHASE=3, state REST, RED=4'b1111, ACK never pulses.
REQ-029 Single request:
- REQ[2] pulse in REST -> ACK[2] pulses once, GREEN[2]=1 for 6 cycles, YELLOW[2]=1 for 2 cycles, RED=4'b1111 for 1 cycle, then REST, PEND=0.
REQ-030 Contention:
- REQ=4'b1011 held one cycle during ALLRED after PHASE=0 -> service order 1,3,0.
- Each green lasts 3 cycles while others are pending; the last green lasts 6 cycles.
REQ-031 Ticks:
- TICK=1 every 3rd cycle, single request -> GREEN lasts 18 cycles and YELLOW lasts 6 cycles.
- Timer never advances in a TICK=0 cycle.
REQ-032 Reset and collision:
- RN low during GREEN[1] at timer=2 -> GREEN=0 and RED=4'b1111 before the next CK edge, PEND=0.
- REQ[1] asserted on its green-entry cycle -> no re-service of channel 1.
REQ-033 Flash (with TRAFFIC_CTRL_FLASH_EN):
- FLASH=1 during YELLOW[0] -> next cycle RED=4'b1111, then alternating 4'b0000/4'b1111.
- FLASH=0 -> ALLRED for 1 cycle, then pending channels are served.
